// File: rtl/data_memory.sv
// Word-organised data RAM for the single-cycle MIPS datapath.
// Synchronous write, combinational read. Out-of-range addresses read as zero and never write.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TOP   = IDX_W + 2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      word_idx;
  logic                  in_range;
  logic                  unused_byte_lanes;

  // address[1:0] selects a byte within the word and is deliberately ignored.
  assign unused_byte_lanes = &{1'b0, address[1:0]};
  assign word_idx          = address[TOP-1:2];

  // Every bit above the word index must be zero; no wrap-around or aliasing.
  generate
    if (ADDR_WIDTH > TOP) begin : g_upper_check
      assign in_range = (address[ADDR_WIDTH-1:TOP] == '0);
    end else begin : g_no_upper
      assign in_range = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && in_range) begin
      mem[word_idx] <= write_data;
    end
  end

  always_comb begin
    read_data = '0;
    if (in_range) begin
      read_data = mem[word_idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Table-driven bench for data_memory: vectors checked before each write edge,
// plus hand sequences for read-during-write and reset priority.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_memory #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .address(address),
    .write_data(write_data),
    .read_data(read_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  task automatic add_vec(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] e, input string n);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  // scoreboard: pop the oldest expectation and compare against the live read port
  task automatic sample(input string name);
    logic [31:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: scoreboard empty, actual=%h", name, read_data);
    end else begin
      e = exp_q.pop_front();
      if (read_data !== e) begin
        tests_failed++;
        $display("FAIL %s: actual=%h required=%h", name, read_data, e);
      end
    end
  endtask

  task automatic drive_read(input logic [31:0] a, input logic [31:0] e, input string name);
    address = a;
    exp_q.push_back(e);
    #1;
    sample(name);
  endtask

  initial begin
    logic [31:0] r_addr;
    tests_run    = 0;
    tests_failed = 0;
    we           = 1'b0;
    address      = 32'h0;
    write_data   = 32'h0;
    rst_n        = 1'b0;

    // initial reset: everything reads zero while held
    #1;
    drive_read(32'h0,  32'h0, "reset_rd_0x0");
    drive_read(32'h4,  32'h0, "reset_rd_0x4");
    drive_read(32'h3C, 32'h0, "reset_rd_0x3c");
    @(negedge clk);
    rst_n = 1'b1;
    drive_read(32'h8, 32'h0, "post_reset_rd_0x8");

    add_vec(1'b1, 32'h0,        32'hA5A5A5A5, 32'h0,        "wr_0x0");
    add_vec(1'b1, 32'h4,        32'h5A5A5A5A, 32'h0,        "wr_0x4");
    add_vec(1'b1, 32'h8,        32'hDEADBEEF, 32'h0,        "wr_0x8");
    add_vec(1'b0, 32'h0,        32'h0,        32'hA5A5A5A5, "rd_0x0");
    add_vec(1'b0, 32'h4,        32'h0,        32'h5A5A5A5A, "rd_0x4");
    add_vec(1'b0, 32'h8,        32'h0,        32'hDEADBEEF, "rd_0x8");
    add_vec(1'b0, 32'h40,       32'h0,        32'h0,        "oor_rd_0x40");
    add_vec(1'b1, 32'h40,       32'h12345678, 32'h0,        "oor_wr_0x40");
    add_vec(1'b0, 32'h0,        32'h0,        32'hA5A5A5A5, "no_alias_0x40");
    add_vec(1'b0, 32'h80000000, 32'h0,        32'h0,        "oor_rd_msb");
    add_vec(1'b1, 32'h80000008, 32'hBBBBBBBB, 32'h0,        "oor_wr_msb");
    add_vec(1'b0, 32'h8,        32'h0,        32'hDEADBEEF, "no_alias_msb");
    add_vec(1'b0, 32'h8,        32'hFFFFFFFF, 32'hDEADBEEF, "we_gate_1");
    add_vec(1'b0, 32'h8,        32'hFFFFFFFF, 32'hDEADBEEF, "we_gate_2");
    add_vec(1'b0, 32'h8,        32'h0,        32'hDEADBEEF, "we_gate_chk");
    add_vec(1'b1, 32'h38,       32'h38383838, 32'h0,        "wr_0x38");
    add_vec(1'b1, 32'h3F,       32'hCAFEF00D, 32'h0,        "wr_0x3f");
    add_vec(1'b0, 32'h3C,       32'h0,        32'hCAFEF00D, "rd_0x3c");
    add_vec(1'b0, 32'h3D,       32'h0,        32'hCAFEF00D, "rd_0x3d");
    add_vec(1'b0, 32'h3B,       32'h0,        32'h38383838, "rd_0x3b");
    add_vec(1'b1, 32'h5,        32'h11111111, 32'h5A5A5A5A, "rdw_old_0x5");
    add_vec(1'b0, 32'h4,        32'h0,        32'h11111111, "rdw_new_0x4");
    add_vec(1'b1, 32'hC,        32'h00000001, 32'h0,        "level_1");
    add_vec(1'b1, 32'hC,        32'h00000002, 32'h00000001, "level_2");
    add_vec(1'b1, 32'hC,        32'h00000003, 32'h00000002, "level_3");
    add_vec(1'b0, 32'hC,        32'h0,        32'h00000003, "level_last");
    for (int k = 0; k < 4; k++) begin
      r_addr = 32'h40 + ($urandom_range(0, 32'h0FFF) << 2);
      add_vec(1'($urandom_range(0, 1)), r_addr, $urandom, 32'h0, "oor_rand");
    end
    add_vec(1'b0, 32'h0,        32'h0,        32'hA5A5A5A5, "rd_0x0_final");

    // each vector: drive after the falling edge, check before the rising edge
    foreach (vecs[i]) begin
      @(negedge clk);
      we         = vecs[i].we;
      write_data = vecs[i].wdata;
      drive_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    @(negedge clk);
    we = 1'b0;

    // read-during-write: old value before the edge, new value right after it
    @(negedge clk);
    we         = 1'b1;
    write_data = 32'h22222222;
    drive_read(32'h4, 32'h11111111, "rdw_pre_edge");
    @(posedge clk);
    exp_q.push_back(32'h22222222);
    #1;
    sample("rdw_post_edge");
    @(negedge clk);
    we = 1'b0;

    // reset mid-cycle with we=1: array cleared, edge while in reset does not write
    @(negedge clk);
    we         = 1'b1;
    write_data = 32'h99999999;
    address    = 32'h8;
    #2;
    rst_n = 1'b0;
    drive_read(32'h8, 32'h0, "rst_mid_0x8");
    @(posedge clk);
    exp_q.push_back(32'h0);
    #1;
    sample("rst_prio_edge_0x8");
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    drive_read(32'h8,  32'h0, "rst_after_0x8");
    drive_read(32'h0,  32'h0, "rst_after_0x0");
    drive_read(32'h3C, 32'h0, "rst_after_0x3c");
    drive_read(32'h4,  32'h0, "rst_after_0x4");

    // memory still writable after reset release
    @(negedge clk);
    we         = 1'b1;
    write_data = 32'h0BADCAFE;
    address    = 32'h10;
    @(negedge clk);
    we = 1'b0;
    drive_read(32'h10, 32'h0BADCAFE, "wr_after_rst");

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: actual=%0d left required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data RAM for the single-cycle MIPS datapath; serves lw/sw from the ALU-computed byte address.
- Synchronous write on the rising clock edge; asynchronous (combinational) read.
- Small fixed-size array: 16 words (64 bytes) by default. Accesses outside the array read as zero and never write.

Parameters:
- DATA_WIDTH, 32, width of each memory word and of the data ports
- ADDR_WIDTH, 32, width of the byte address port
- DEPTH, 16, number of words; must be a power of two, at least 2

Ports:
- clk  input  1  system clock; all writes occur on its rising edge
- rst_n  input  1  asynchronous active-low reset; clears the whole array
- we  input  1  write enable, sampled on the rising edge of clk
- address  input  ADDR_WIDTH  byte address; word index = address[log2(DEPTH)+1:2]
- write_data  input  DATA_WIDTH  data to store when we=1
- read_data  output  DATA_WIDTH  combinational read of the addressed word

Behaviour:
- Addressing:
  - Byte address; address[1:0] is ignored, so misaligned addresses access the containing word.
  - In range when address < DEPTH*4 (0x00–0x3C for DEPTH=16); otherwise out of range. All upper bits are checked.
- Reset:
  - rst_n=0 asynchronously sets every word to 0, regardless of clk. read_data therefore reads 0 for any address during and after reset.
  - Reset has priority over a concurrent write; no write occurs on an edge while rst_n=0.
- Write:
  - On posedge clk with rst_n=1, we=1 and address in range, mem[word index] <= write_data.
  - we=0 or out-of-range address: the array is unchanged. No wrap-around, no aliasing.
- Read:
  - read_data = mem[word index] when in range, else 0.
  - Purely combinational: zero-cycle latency, follows address and array contents within the same delta.
  - Read-during-write, same word: read_data shows the old value until the rising edge, then the new value immediately after the edge.
- we is a level: it stays asserted across several edges → same word rewritten each edge; last data wins.
- No X propagation from an unwritten word: every word is defined after reset. Before the first reset, contents are unspecified.
- No handshake, no stall, no error output.

Test Plan:
- Reset: rst_n=0 with prior contents → read_data=0x00000000 at addresses 0x0, 0x4, 0x3C; release rst_n, then read 0x8 → 0x00000000.
- Basic write/read: we=1, address=0x0, write_data=0xA5A5A5A5, one rising edge; we=0 → read_data=0xA5A5A5A5. Repeat with 0x4/0x5A5A5A5A and 0x8/0xDEADBEEF, each read back exactly; address 0x0 still reads 0xA5A5A5A5.
- Out of range: address=0x40 → read_data=0x00000000. Write 0x12345678 to 0x40 with we=1, then read 0x0 → still 0xA5A5A5A5 (no aliasing). Also check address 0x80000000 → 0.
- Write-enable gating: we=0, address=0x8, write_data=0xFFFFFFFF, clock edges → 0x8 still reads 0xDEADBEEF.
- Alignment and boundary: write 0xCAFEF00D to 0x3F → read 0x3C returns 0xCAFEF00D; address 0x3B reads word 0xE (0x38).
- Read-during-write and reset priority:
  - address=0x4, we=1, write_data=0x11111111 → read_data=0x5A5A5A5A before the edge, 0x11111111 after it.
  - Assert rst_n=0 mid-cycle with we=1 → all words 0; no write lands on the next edge while rst_n is low.
